// File: rtl/weight_pkg.sv
// Shared definitions for the weight buffer fill path: size derivations, FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package weight_pkg;

   // Default geometry of the weight matrix and the systolic row
   localparam int DATA_WIDTH_DEF  = 32;
   localparam int FEATURE_LEN_DEF = 128;
   localparam int PSYS_DEF        = 32;

   // Number of buffer rows needed to hold a featureLen x featureLen matrix
   function automatic int calc_num_rows(input int feature_len, input int words_per_row);
      return (feature_len * feature_len) / words_per_row;
   endfunction

   // Counter/address width for n distinct values, never narrower than one bit
   function automatic int calc_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NUM_ROWS_DEF   = calc_num_rows(FEATURE_LEN_DEF, PSYS_DEF);
   localparam int ADDR_WIDTH_DEF = calc_width(NUM_ROWS_DEF);
   localparam int ROW_WIDTH_DEF  = DATA_WIDTH_DEF * PSYS_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/weight_word_packer.sv
// Packs psys consecutive accepted words into one row, lane 0 = first word.
// Latency: row and row_complete are combinational on the accept of the last lane.
// Backpressure: none; advances only on accept, which the caller gates.
module weight_word_packer
   import weight_pkg::*;
#(
   parameter int dataWidth = DATA_WIDTH_DEF,
   parameter int psys      = PSYS_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        accept,
   input  logic [dataWidth-1:0]        word,
   output logic                        row_complete,
   output logic [dataWidth*psys-1:0]   row
);

   localparam int                LANE_W    = calc_width(psys);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(psys - 1);

   logic [LANE_W-1:0]         lane;
   logic [dataWidth*psys-1:0] pack;

   // Store each accepted word in its lane and step the lane counter, wrapping per row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane <= '0;
         pack <= '0;
      end else if (accept) begin
         pack[lane*dataWidth +: dataWidth] <= word;
         lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
      end
   end

   // Present the row with the word being accepted already merged in, so the
   // completed row can be captured on the same edge as its last word
   always_comb begin
      row = pack;
      row[lane*dataWidth +: dataWidth] = word;
   end

   assign row_complete = accept && (lane == LAST_LANE);

endmodule

// File: rtl/weight_buffer_loader.sv
// Streams weight words into the weight buffer, one psys-word row per write, rows 0..NUM_ROWS-1.
// Latency: write strobe one cycle after a row's last word; done one cycle after the final write.
// Backpressure: in_ready high for the whole load; no internal stalls, one word per cycle sustained.
module weight_buffer_loader
   import weight_pkg::*;
#(
   parameter  int dataWidth    = DATA_WIDTH_DEF,
   parameter  int featureLen   = FEATURE_LEN_DEF,
   parameter  int psys         = PSYS_DEF,
   localparam int NUM_ROWS     = calc_num_rows(featureLen, psys),
   localparam int addressWidth = calc_width(NUM_ROWS),
   localparam int rowWidth     = dataWidth * psys
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [dataWidth-1:0]    in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    wb_en,
   output logic                    wb_we,
   output logic [addressWidth-1:0] wb_addr,
   output logic [rowWidth-1:0]     wb_din,
   output logic                    busy,
   output logic                    done
);

   localparam logic [addressWidth-1:0] LAST_ROW = addressWidth'(NUM_ROWS - 1);

   state_t                  state;
   logic [addressWidth-1:0] row_cnt;
   logic                    accept;
   logic                    row_complete;
   logic [rowWidth-1:0]     row;

   assign accept = in_valid && in_ready;

   weight_word_packer #(
      .dataWidth (dataWidth),
      .psys      (psys)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .accept       (accept),
      .word         (in_data),
      .row_complete (row_complete),
      .row          (row)
   );

   // Load sequencing plus the registered write port: a completed row is latched
   // into wb_din/wb_addr and strobed for exactly one cycle while the packer
   // already fills the next row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         row_cnt  <= '0;
         wb_addr  <= '0;
         wb_din   <= '0;
         in_ready <= 1'b0;
         wb_en    <= 1'b0;
         wb_we    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         wb_en <= 1'b0;
         wb_we <= 1'b0;
         done  <= 1'b0;

         if (row_complete) begin
            wb_din  <= row;
            wb_addr <= row_cnt;
            wb_en   <= 1'b1;
            wb_we   <= 1'b1;
            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (row_complete && (row_cnt == LAST_ROW)) begin
                  state    <= FLUSH;
                  in_ready <= 1'b0;
               end
            end
            FLUSH: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Randomized bench for weight_buffer_loader against a row/lane arithmetic model.
// Latency: checks write strobe spacing and done one cycle after the final write.
// Backpressure: drives random in_valid bubbles; loader never stalls.
module tb_weight_buffer_loader;
   import weight_pkg::*;

   localparam int DW    = DATA_WIDTH_DEF;
   localparam int PS    = PSYS_DEF;
   localparam int NR    = NUM_ROWS_DEF;
   localparam int AW    = ADDR_WIDTH_DEF;
   localparam int RW    = ROW_WIDTH_DEF;
   localparam int TOTAL = NR * PS;

   logic          clk;
   logic          rst;
   logic          start;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          wb_en;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [RW-1:0] wb_din;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;

   // monitor-owned
   int          cyc = 0;
   int          wr_cnt = 0;
   int          last_wr_cyc = 0;
   int          done_cnt = 0;
   logic        prev_we = 1'b0;
   logic [RW-1:0] prev_din = '0;

   // stimulus-owned
   int wr_base = 0;
   bit cont_mode = 1'b0;

   weight_buffer_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wb_en    (wb_en),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_din   (wb_din),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write-port monitor: every write must be the next row in order and hold
   // words r*PS+k in lane k; outputs hold between writes
   always @(negedge clk) begin
      if (rst) begin
         check_eq("en_matches_we", wb_en, wb_we);
         if (wb_we) begin
            check_eq("strobe_len", prev_we, 1'b0);
            check_eq("wr_addr", wb_addr, wr_cnt - wr_base);
            for (int k = 0; k < PS; k++)
               check_eq("wr_lane", wb_din[k*DW +: DW], DW'((wr_cnt - wr_base) * PS + k));
            if (cont_mode && (wr_cnt - wr_base) > 0)
               check_eq("wr_spacing", cyc - last_wr_cyc, PS);
            last_wr_cyc = cyc;
            wr_cnt++;
         end else begin
            check_eq("din_hold", wb_din === prev_din, 1'b1);
         end
         if (done) begin
            check_eq("done_lag", cyc - last_wr_cyc, 1);
            check_eq("done_rows", wr_cnt - wr_base, NR);
            done_cnt++;
         end
      end
      prev_we  = wb_we;
      prev_din = wb_din;
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer words 0..n-1 in order; a word advances only when in_ready was high
   task automatic feed(input int n, input bit bubble, input int inject_at);
      int idx = 0;
      int guard = 0;
      bit v;
      while (idx < n && guard < n * 4 + 200) begin
         @(negedge clk);
         v        = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         in_data  = v ? DW'(idx) : DW'($urandom);
         start    = (inject_at >= 0) && (idx == inject_at) && v;
         if (v && in_ready) idx++;
         guard++;
      end
      check_eq("feed_count", idx, n);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Run a full matrix load, pulsing start again in the DONE cycle
   task automatic full_load(input bit bubble, input int inject_at);
      int  d0;
      bit  seen;
      d0        = done_cnt;
      wr_base   = wr_cnt;
      cont_mode = !bubble;
      pulse_start();
      check_eq("load_busy", busy, 1'b1);
      check_eq("load_ready", in_ready, 1'b1);
      feed(TOTAL, bubble, inject_at);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check_eq("done_seen", seen, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("post_busy", busy, 1'b0);
      check_eq("post_ready", in_ready, 1'b0);
      check_eq("post_writes", wr_cnt - wr_base, NR);
      check_eq("post_done_cnt", done_cnt - d0, 1);
      cont_mode = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"}, in_ready, 1'b0);
      check_eq({tag, "_wb_en"},    wb_en,    1'b0);
      check_eq({tag, "_wb_we"},    wb_we,    1'b0);
      check_eq({tag, "_busy"},     busy,     1'b0);
      check_eq({tag, "_done"},     done,     1'b0);
      check_eq({tag, "_wb_addr"},  wb_addr,  '0);
      check_eq({tag, "_wb_din"},   wb_din === '0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_ready", in_ready, 1'b0);

      // Abort after 40 words: row 0 written, row 1 partial and discarded
      wr_base = wr_cnt;
      pulse_start();
      feed(40, 1'b0, -1);
      rst = 1'b0;
      #1;
      check_reset_outputs("abort");
      check_eq("abort_rows", wr_cnt - wr_base, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("abort_no_more", wr_cnt - wr_base, 1);

      // Reload restarts at row 0, lane 0
      wr_base = wr_cnt;
      pulse_start();
      feed(2 * PS, 1'b0, -1);
      repeat (3) @(negedge clk);
      check_eq("reload_rows", wr_cnt - wr_base, 2);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Continuous load with a stray start mid-load
      full_load(1'b0, 5000);

      // Bubbled load
      full_load(1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
